// File: rtl/spi_flash_sequencer.sv
// Command-level sequencer in front of spi_controller: opcode, optional address, dummy and data phases per request.
// Optional macro SPI_FLASH_SEQUENCER_WIP_POLL_EN appends automatic 0x05 status polling until WIP clears.
module spi_flash_sequencer #(
    parameter int         LEN_BITS       = 16,
    parameter logic [7:0] FILL_BYTE      = 8'hFF,
    parameter int         CS_HIGH_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_opcode,
    input  logic                cmd_has_addr,
    input  logic [23:0]         cmd_addr,
    input  logic [3:0]          cmd_dummy,
    input  logic                cmd_write,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic [7:0]          wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                spi_enable,
    output logic [7:0]          spi_tx_data,
    output logic                spi_tx_strobe,
    input  logic                spi_tx_ready,
    input  logic                spi_rx_strobe,
    input  logic [7:0]          spi_rx_data
);
    // Holds 1 + 3 + 15 + (2^LEN_BITS - 1) bytes without wrapping.
    localparam int CNT_W = LEN_BITS + 2;
    localparam int CS_W  = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

`ifdef SPI_FLASH_SEQUENCER_WIP_POLL_EN
    typedef enum logic [3:0] {
        S_IDLE, S_OPCODE, S_ADDR2, S_ADDR1, S_ADDR0, S_DUMMY, S_DATA, S_DRAIN, S_CSHIGH,
        S_POLL_OP, S_POLL_FILL
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_OPCODE, S_ADDR2, S_ADDR1, S_ADDR0, S_DUMMY, S_DATA, S_DRAIN, S_CSHIGH
    } state_t;
`endif

    state_t              state_reg, state_next;
    state_t              after_addr_state, after_dummy_state;
    logic [7:0]          opcode_reg;
    logic                has_addr_reg;
    logic [23:0]         addr_reg;
    logic [3:0]          dummy_reg;
    logic                write_reg;
    logic [LEN_BITS-1:0] len_reg;
    logic [LEN_BITS-1:0] left_reg, left_next, after_addr_left;
    logic [CS_W-1:0]     cs_cnt_reg, cs_cnt_next;
    logic [CNT_W-1:0]    tx_cnt_reg, rx_cnt_reg, header_len;
    logic                armed_reg;
    logic                done_reg;
    logic                rd_valid_reg;
    logic [7:0]          rd_data_reg;
    logic                accept, finish, frame_start, in_poll;
    logic                tx_strobe, wr_take;
    logic [7:0]          tx_byte;

`ifdef SPI_FLASH_SEQUENCER_WIP_POLL_EN
    logic in_poll_reg, wip_reg, poll_start, poll_req;
    assign in_poll     = in_poll_reg;
    assign frame_start = accept || poll_start;
    assign poll_req    = write_reg ||
                         ((len_reg == '0) && (opcode_reg != 8'h06) && (opcode_reg != 8'h04));
`else
    assign in_poll     = 1'b0;
    assign frame_start = accept;
`endif

    // Header bytes (opcode, address, dummy) whose rx bytes are never returned.
    assign header_len = CNT_W'(1) + (has_addr_reg ? CNT_W'(3) : CNT_W'(0)) + CNT_W'(dummy_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            armed_reg    <= 1'b0;
            opcode_reg   <= '0;
            has_addr_reg <= 1'b0;
            addr_reg     <= '0;
            dummy_reg    <= '0;
            write_reg    <= 1'b0;
            len_reg      <= '0;
            left_reg     <= '0;
            cs_cnt_reg   <= '0;
            tx_cnt_reg   <= '0;
            rx_cnt_reg   <= '0;
            done_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            armed_reg    <= 1'b1;
            left_reg     <= left_next;
            cs_cnt_reg   <= cs_cnt_next;
            done_reg     <= finish;
            rd_valid_reg <= 1'b0;
            if (accept) begin
                opcode_reg   <= cmd_opcode;
                has_addr_reg <= cmd_has_addr;
                addr_reg     <= cmd_addr;
                dummy_reg    <= cmd_dummy;
                write_reg    <= cmd_write;
                len_reg      <= cmd_len;
            end
            if (frame_start) begin
                tx_cnt_reg <= '0;
                rx_cnt_reg <= '0;
            end else begin
                if (tx_strobe) begin
                    tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
                end
                if (spi_rx_strobe && (state_reg != S_IDLE)) begin
                    rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                    if (!write_reg && !in_poll && (rx_cnt_reg >= header_len)) begin
                        rd_data_reg  <= spi_rx_data;
                        rd_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SPI_FLASH_SEQUENCER_WIP_POLL_EN
    // Status byte is the second rx byte of each poll frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_poll_reg <= 1'b0;
            wip_reg     <= 1'b0;
        end else begin
            if (accept) begin
                in_poll_reg <= 1'b0;
            end else if (poll_start) begin
                in_poll_reg <= 1'b1;
            end
            if (in_poll_reg && spi_rx_strobe && (state_reg != S_IDLE) && !poll_start &&
                (rx_cnt_reg == CNT_W'(1))) begin
                wip_reg <= spi_rx_data[0];
            end
        end
    end
`endif

    always_comb begin
        state_next        = state_reg;
        left_next         = left_reg;
        cs_cnt_next       = cs_cnt_reg;
        accept            = 1'b0;
        finish            = 1'b0;
        tx_strobe         = 1'b0;
        tx_byte           = 8'h00;
        wr_take           = 1'b0;
`ifdef SPI_FLASH_SEQUENCER_WIP_POLL_EN
        poll_start        = 1'b0;
`endif
        after_dummy_state = (len_reg != '0) ? S_DATA : S_DRAIN;
        after_addr_state  = (dummy_reg != 4'd0) ? S_DUMMY : after_dummy_state;
        after_addr_left   = (dummy_reg != 4'd0) ? LEN_BITS'(dummy_reg) : len_reg;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = S_OPCODE;
                end
            end
            // First byte of a frame goes out with the chip-select edge, no ready needed.
            S_OPCODE: begin
                tx_strobe = 1'b1;
                tx_byte   = opcode_reg;
                if (has_addr_reg) begin
                    state_next = S_ADDR2;
                end else begin
                    state_next = after_addr_state;
                    left_next  = after_addr_left;
                end
            end
            S_ADDR2: begin
                tx_byte = addr_reg[23:16];
                if (spi_tx_ready) begin
                    tx_strobe  = 1'b1;
                    state_next = S_ADDR1;
                end
            end
            S_ADDR1: begin
                tx_byte = addr_reg[15:8];
                if (spi_tx_ready) begin
                    tx_strobe  = 1'b1;
                    state_next = S_ADDR0;
                end
            end
            S_ADDR0: begin
                tx_byte = addr_reg[7:0];
                if (spi_tx_ready) begin
                    tx_strobe  = 1'b1;
                    state_next = after_addr_state;
                    left_next  = after_addr_left;
                end
            end
            S_DUMMY: begin
                tx_byte = FILL_BYTE;
                if (spi_tx_ready) begin
                    tx_strobe = 1'b1;
                    if (left_reg == LEN_BITS'(1)) begin
                        state_next = after_dummy_state;
                        left_next  = len_reg;
                    end else begin
                        left_next = left_reg - LEN_BITS'(1);
                    end
                end
            end
            // Writes stall here with CS held for as long as wr_valid stays low.
            S_DATA: begin
                tx_byte = write_reg ? wr_data : FILL_BYTE;
                if (spi_tx_ready && (wr_valid || !write_reg)) begin
                    tx_strobe = 1'b1;
                    wr_take   = write_reg;
                    if (left_reg == LEN_BITS'(1)) begin
                        state_next = S_DRAIN;
                    end else begin
                        left_next = left_reg - LEN_BITS'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (rx_cnt_reg == tx_cnt_reg) begin
                    state_next  = S_CSHIGH;
                    cs_cnt_next = CS_W'(CS_HIGH_CYCLES - 1);
                end
            end
            S_CSHIGH: begin
                if (cs_cnt_reg == '0) begin
`ifdef SPI_FLASH_SEQUENCER_WIP_POLL_EN
                    if ((in_poll_reg && wip_reg) || (!in_poll_reg && poll_req)) begin
                        state_next = S_POLL_OP;
                        poll_start = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        finish     = 1'b1;
                    end
`else
                    state_next = S_IDLE;
                    finish     = 1'b1;
`endif
                end else begin
                    cs_cnt_next = cs_cnt_reg - CS_W'(1);
                end
            end
`ifdef SPI_FLASH_SEQUENCER_WIP_POLL_EN
            S_POLL_OP: begin
                tx_strobe  = 1'b1;
                tx_byte    = 8'h05;
                state_next = S_POLL_FILL;
            end
            S_POLL_FILL: begin
                tx_byte = FILL_BYTE;
                if (spi_tx_ready) begin
                    tx_strobe  = 1'b1;
                    state_next = S_DRAIN;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    assign cmd_ready     = armed_reg && (state_reg == S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign done          = done_reg;
    assign spi_enable    = (state_reg != S_IDLE) && (state_reg != S_CSHIGH);
    assign spi_tx_strobe = tx_strobe;
    assign spi_tx_data   = tx_byte;
    assign wr_ready      = wr_take;
    assign rd_valid      = rd_valid_reg;
    assign rd_data       = rd_data_reg;
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Scoreboard bench for spi_flash_sequencer: controller/flash model, write-data source and tx/rd monitors.
`timescale 1ns/1ps
module tb_spi_flash_sequencer;
    localparam int         LEN_BITS = 16;
    localparam logic [7:0] FILL     = 8'hFF;
    localparam int         CSH      = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid, cmd_ready, cmd_has_addr, cmd_write;
    logic [7:0]          cmd_opcode;
    logic [23:0]         cmd_addr;
    logic [3:0]          cmd_dummy;
    logic [LEN_BITS-1:0] cmd_len;
    logic [7:0]          wr_data, rd_data, spi_tx_data, spi_rx_data;
    logic                wr_valid, wr_ready, rd_valid, busy, done;
    logic                spi_enable, spi_tx_strobe, spi_tx_ready, spi_rx_strobe;

    always #5 clk = ~clk;

    spi_flash_sequencer #(.LEN_BITS(LEN_BITS), .FILL_BYTE(FILL), .CS_HIGH_CYCLES(CSH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_has_addr(cmd_has_addr), .cmd_addr(cmd_addr), .cmd_dummy(cmd_dummy),
        .cmd_write(cmd_write), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .spi_enable(spi_enable), .spi_tx_data(spi_tx_data), .spi_tx_strobe(spi_tx_strobe),
        .spi_tx_ready(spi_tx_ready), .spi_rx_strobe(spi_rx_strobe), .spi_rx_data(spi_rx_data)
    );

    typedef struct { int due; logic [7:0] b; } rx_t;

    int          checks = 0, failures = 0;
    int          cyc = 0;
    logic [7:0]  exp_tx[$], exp_rd[$], wr_q[$];
    rx_t         pend_q[$];
    logic [7:0]  resp_mem [0:511];
    int          done_cnt, wr_cnt, rd_seen, frames, frame_idx;
    int          cur_wip_polls = 0, stall_after = -1, wr_sent = 0, stall = 0;
    int          ready_hold = 0, low_cnt = CSH;
    logic        en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Flash model: frame 1 answers from resp_mem, later frames are status polls.
    function automatic logic [7:0] flash_byte(input int f, input int idx);
        logic [6:0] junk;
        junk = 7'($urandom);
        if (f <= 1) return (idx < 512) ? resp_mem[idx] : 8'h00;
        if (idx == 1) return {junk, ((f - 1) <= cur_wip_polls) ? 1'b1 : 1'b0};
        return 8'h00;
    endfunction

    // Controller model: random ready gaps, in-order rx with random latency.
    initial begin
        spi_tx_ready = 1'b1; spi_rx_strobe = 1'b0; spi_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete(); ready_hold = 0; en_prev = 1'b0; low_cnt = CSH;
            end else begin
                if (spi_enable && !en_prev) begin
                    chk("cs_low_gap", int'(low_cnt >= CSH), 1);
                    frames++;
                    frame_idx = 0;
                end
                if (!spi_enable && en_prev) chk("drain_before_cs_fall", pend_q.size(), 0);
                low_cnt = spi_enable ? 0 : low_cnt + 1;
                if (spi_tx_strobe) begin
                    rx_t r;
                    r.due = cyc + int'($urandom_range(1, 6));
                    r.b   = flash_byte(frames, frame_idx);
                    pend_q.push_back(r);
                    frame_idx++;
                    ready_hold = int'($urandom_range(0, 3));
                end
                en_prev = spi_enable;
            end
            @(posedge clk); #1;
            spi_rx_strobe = 1'b0;
            if (!reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                spi_rx_strobe = 1'b1;
                spi_rx_data   = pend_q[0].b;
                void'(pend_q.pop_front());
            end
            if (ready_hold > 0) begin spi_tx_ready = 1'b0; ready_hold--; end
            else spi_tx_ready = 1'b1;
        end
    end

    // Write-data source with random gaps and an optional long stall.
    initial begin
        wr_valid = 1'b0; wr_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset && wr_valid && wr_ready && wr_q.size() > 0) begin
                void'(wr_q.pop_front());
                wr_sent++;
                if (wr_sent == stall_after) stall = 200;
            end
            @(posedge clk); #1;
            if (stall > 0) begin stall--; wr_valid = 1'b0; end
            else if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                wr_valid = 1'b1; wr_data = wr_q[0];
            end else wr_valid = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (spi_tx_strobe) begin
                chk("tx_under_cs", int'(spi_enable), 1);
                if (exp_tx.size() == 0) chk("tx_unexpected", int'(spi_tx_data), -1);
                else chk("tx_byte", int'(spi_tx_data), int'(exp_tx.pop_front()));
            end
            if (rd_valid) begin
                rd_seen++;
                if (exp_rd.size() == 0) chk("rd_unexpected", int'(rd_data), -1);
                else chk("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
            end
            if (done) done_cnt++;
            if (wr_ready) wr_cnt++;
        end
    end

    task automatic rand_resp();
        for (int i = 0; i < 512; i++) resp_mem[i] = 8'($urandom);
    endtask

    task automatic run_cmd(input logic [7:0] op, input bit ha, input logic [23:0] ad,
                           input int dm, input bit wr, input int ln, input int stall_at,
                           input int wips, input int abort_rd);
        int h, exp_frames;
        bit got;
        logic [7:0] d;
        h = 1 + (ha ? 3 : 0) + dm;
        exp_tx.push_back(op);
        if (ha) begin exp_tx.push_back(ad[23:16]); exp_tx.push_back(ad[15:8]); exp_tx.push_back(ad[7:0]); end
        repeat (dm) exp_tx.push_back(FILL);
        for (int k = 0; k < ln; k++) begin
            if (wr) begin d = 8'($urandom); wr_q.push_back(d); exp_tx.push_back(d); end
            else begin exp_tx.push_back(FILL); exp_rd.push_back(resp_mem[h + k]); end
        end
        exp_frames = 1;
`ifdef SPI_FLASH_SEQUENCER_WIP_POLL_EN
        if (wr || (ln == 0 && op != 8'h06 && op != 8'h04)) begin
            for (int p = 0; p <= wips; p++) begin exp_tx.push_back(8'h05); exp_tx.push_back(FILL); end
            exp_frames = 2 + wips;
        end
`endif
        cur_wip_polls = wips; done_cnt = 0; wr_cnt = 0; rd_seen = 0; frames = 0;
        wr_sent = 0; stall_after = stall_at;

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_has_addr = ha; cmd_addr = ad;
        cmd_dummy = 4'(dm); cmd_write = wr; cmd_len = LEN_BITS'(ln);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        chk("cmd_accepted", int'(got), 1);
        @(posedge clk); #1;
        chk("busy_after_accept", int'(busy), 1);
        chk("ready_low_when_busy", int'(cmd_ready), 0);
        // Junk request while busy must be ignored.
        cmd_opcode = 8'($urandom); cmd_len = LEN_BITS'($urandom_range(1, 9));
        repeat (4) @(posedge clk);
        #1 cmd_valid = 1'b0;

        if (abort_rd > 0) begin
            for (int i = 0; i < 5000 && rd_seen < abort_rd; i++) @(negedge clk);
            chk("reached_mid_data", int'(rd_seen >= abort_rd), 1);
            #2 reset = 1'b1;
            #1;
            chk("rst_async_cs", int'(spi_enable), 0);
            chk("rst_async_busy", int'(busy), 0);
            chk("rst_async_strobe", int'(spi_tx_strobe), 0);
            chk("rst_async_rd_valid", int'(rd_valid), 0);
            exp_tx.delete(); exp_rd.delete(); wr_q.delete();
            repeat (20) @(negedge clk);
            reset = 1'b0;
            return;
        end

        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
        chk("done_seen", int'(done_cnt > 0), 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("tx_all_sent", exp_tx.size(), 0);
        chk("rd_all_seen", exp_rd.size(), 0);
        chk("wr_ready_pulses", wr_cnt, wr ? ln : 0);
        chk("cs_frames", frames, exp_frames);
        chk("idle_not_busy", int'(busy), 0);
        chk("idle_ready", int'(cmd_ready), 1);
        exp_tx.delete(); exp_rd.delete(); wr_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_has_addr = 1'b0;
        cmd_addr = 24'h0; cmd_dummy = 4'h0; cmd_write = 1'b0; cmd_len = '0;
        #1;
        chk("rst_cs", int'(spi_enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_strobe", int'(spi_tx_strobe), 0);
        chk("rst_tx_data", int'(spi_tx_data), 0);
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 chk("ready_before_first_clk", int'(cmd_ready), 0);
        @(negedge clk);
        chk("ready_after_first_clk", int'(cmd_ready), 1);

        // JEDEC ID
        rand_resp(); resp_mem[1] = 8'hEF; resp_mem[2] = 8'h40; resp_mem[3] = 8'h18;
        run_cmd(8'h9F, 1'b0, 24'h0, 0, 1'b0, 3, -1, 0, 0);
        // Fast read
        rand_resp(); run_cmd(8'h0B, 1'b1, 24'h123456, 1, 1'b0, 2, -1, 0, 0);
        // Page program with a 200-cycle write stall after byte 2
        rand_resp(); run_cmd(8'h02, 1'b1, 24'h000100, 0, 1'b1, 4, 2, 0, 0);
        // Write enable
        rand_resp(); run_cmd(8'h06, 1'b0, 24'h0, 0, 1'b0, 0, -1, 0, 0);
        // Sector erase, WIP busy for three polls
        rand_resp(); run_cmd(8'h20, 1'b1, 24'h001000, 0, 1'b0, 0, -1, 3, 0);
        // Reset in the middle of a long read, then a clean command
        rand_resp(); run_cmd(8'h03, 1'b1, 24'h00ABCD, 0, 1'b0, 256, -1, 0, 10);
        rand_resp(); run_cmd(8'h03, 1'b1, 24'h7E0010, 0, 1'b0, 5, -1, 0, 0);

        for (int n = 0; n < 24; n++) begin
            rand_resp();
            run_cmd(8'($urandom), 1'($urandom), 24'($urandom), int'($urandom_range(0, 15)),
                    1'($urandom), int'($urandom_range(0, 20)), -1, int'($urandom_range(0, 2)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_flash_sequencer.md
Name: spi_flash_sequencer

Overview:
- Command-level sequencer in front of spi_controller's byte interface. Takes one flash transaction per request: opcode, optional 24-bit address, dummy bytes, N data bytes in or out.
- Emits the byte stream, owns spi_enable (chip select) and discards header rx bytes. Returns data-phase rx bytes and enforces minimum CS-high time between transactions.
- Used by the UART flasher command parser for ID, read, program and erase operations.

Parameters:
- LEN_BITS, 16, width of cmd_len; max data bytes = 2^LEN_BITS-1.
- FILL_BYTE, 8'hFF, tx byte sent during dummy and read-data phases.
- CS_HIGH_CYCLES, 16, minimum clk cycles spi_enable stays low after a transaction, must be >= 1.

Ports:
- clk  in  1  system clock (96 MHz domain).
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid && cmd_ready.
- cmd_opcode  in  8  flash opcode.
- cmd_has_addr  in  1  send 3 address bytes MSB first.
- cmd_addr  in  24  flash address.
- cmd_dummy  in  4  dummy byte count 0..15.
- cmd_write  in  1  1 = data phase sourced from wr_*; 0 = data phase read.
- cmd_len  in  LEN_BITS  data-phase byte count; 0 is legal.
- wr_data  in  8  write byte.
- wr_valid  in  1  write byte available.
- wr_ready  out  1  one-cycle pulse when wr_data is consumed.
- rd_data  out  8  read byte, held until next rd_valid.
- rd_valid  out  1  one-cycle strobe per data-phase rx byte; no backpressure.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- spi_enable  out  1  to spi_controller; high = CS asserted.
- spi_tx_data  out  8  byte to controller.
- spi_tx_strobe  out  1  one-cycle byte strobe.
- spi_tx_ready  in  1  controller can take next byte.
- spi_rx_strobe  in  1  controller received a byte.
- spi_rx_data  in  8  received byte.

Behaviour:
- Reset (async, any state): state=IDLE.
  - Outputs: spi_enable=0, spi_tx_strobe=0, spi_tx_data=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0.
  - cmd_ready=1 after the first clk following reset deassertion.
- Accept: latch all cmd_* fields, set busy=1, then enter OPCODE on the next cycle.
- Controller rule: the first byte is strobed in the same cycle spi_enable rises (0->1). Each later byte is strobed only in a cycle with spi_tx_ready=1. At most one strobe per cycle.
- States:
  - IDLE.
  - OPCODE: sends opcode.
  - ADDR2/ADDR1/ADDR0: sends addr[23:16], [15:8], [7:0]; skipped if !cmd_has_addr.
  - DUMMY: sends FILL_BYTE x cmd_dummy; skipped if 0.
  - DATA: sends cmd_len bytes.
  - DRAIN: waits until rx count == tx count.
  - CSHIGH: spi_enable=0 for CS_HIGH_CYCLES cycles.
  - IDLE with done pulse.
- DATA write: send a byte only when wr_valid && spi_tx_ready. wr_ready pulses in the strobe cycle. If wr_valid=0, stall with spi_enable held high and no strobe, indefinitely.
- DATA read: send FILL_BYTE; wr_ready stays 0.
- rx counter: counts every spi_rx_strobe. Header H = 1 + 3*has_addr + dummy. rx bytes with index < H are dropped. Bytes with index >= H update rd_data and pulse rd_valid the following cycle, but only when !cmd_write. For write commands all rx bytes are dropped.
- cmd_len=0: DATA is skipped; opcode/address-only commands (0x06, 0x20 sector erase) are legal.
- DRAIN is mandatory: spi_enable must not fall before the last rx_strobe.
- An rx_strobe coinciding with a tx_strobe is counted; no byte is lost.
- Counters are sized for 1+3+15+(2^LEN_BITS-1) bytes. No wrap within a transaction.
- cmd_valid during busy is ignored (cmd_ready=0).

Optional Feature:
- Macro SPI_FLASH_SEQUENCER_WIP_POLL_EN.
- When defined, a write command, or a zero-length command whose opcode is not 0x06/0x04, is followed after CSHIGH by an automatic status poll:
  - Sends 0x05 followed by FILL_BYTE, in a separate CS assertion each, until rx bit0 (WIP)=0.
  - CSHIGH is applied between polls.
  - Poll bytes never assert rd_valid. done pulses only after WIP=0 is seen. busy stays high throughout.
- When undefined: no poll; done follows the first CSHIGH. Poll logic is absent from the netlist.

Test Plan:
- JEDEC ID: opcode 9F, has_addr=0, dummy=0, read, len=3; model returns xx,EF,40,18 -> tx 9F,FF,FF,FF; rd_valid x3 with EF,40,18; spi_enable low >=16 cycles; done x1.
- Fast read: opcode 0B, addr 123456, dummy=1, len=2 -> tx 0B,12,34,56,FF,FF,FF; only the last 2 rx bytes appear on rd_data.
- Page program: opcode 02, addr 000100, write, len=4, wr_valid dropped for 200 cycles after byte 2 -> tx 02,00,01,00,D0..D3; spi_enable stays high during the stall; 4 wr_ready pulses; rd_valid never asserts.
- Write enable: opcode 06, len=0 -> single byte 06; spi_enable high for exactly one byte; done.
- Reset asserted mid-DATA of a len=256 read -> spi_enable=0 and busy=0 asynchronously; next command starts cleanly with opcode first.
- With SPI_FLASH_SEQUENCER_WIP_POLL_EN: sector erase 20 addr 001000; model WIP=1 for 3 polls then 0 -> four 05,FF frames; done only after the fourth; no rd_valid.
